dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DBITS, default 32, data and address width.
REQ-002 SHALL have parameter MAX_LOCK, default 16, maximum consecutive cycles a DMA lock may block a pending CPU request.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have CPU port inputs cpu_req 1, cpu_we 1, cpu_addr DBITS, cpu_wdata DBITS.
REQ-006 SHALL have CPU port outputs cpu_gnt 1, cpu_rvalid 1, cpu_rdata DBITS, cpu_err 1.
REQ-007 SHALL have DMA port inputs dma_req 1, dma_we 1, dma_lock 1, dma_addr DBITS, dma_wdata DBITS.
REQ-008 SHALL have DMA port outputs dma_gnt 1, dma_rvalid 1, dma_rdata DBITS, dma_err 1.
REQ-009 SHALL have memory outputs mem_en 1, mem_we 1, mem_addr DBITS, mem_wdata DBITS, and input mem_rdata DBITS (synchronous read, data valid one cycle after mem_en).
REQ-010 SHALL have outputs stat_cpu_cnt 16, stat_dma_cnt 16, stat_conflict_cnt 16.

Function
REQ-011 SHALL grant at most one requester per cycle; cpu_gnt and dma_gnt are combinational from current req inputs and registered state, never both 1.
REQ-012 SHALL, with only one req high, grant that requester the same cycle.
REQ-013 SHALL, with both req high and no active lock, grant the requester not served last (last_owner register); last_owner resets to DMA, so CPU wins the first conflict.
REQ-014 SHALL treat lock as active when the previous cycle granted DMA with dma_lock=1 and dma_req is still 1; while active, DMA is granted and CPU is held off.
REQ-015 SHALL count consecutive cycles where lock is active and cpu_req=1; when the count reaches MAX_LOCK, SHALL ignore the lock for one cycle, grant CPU, and clear the count.
REQ-016 SHALL clear the lock counter when cpu_req=0, lock is inactive, or CPU is granted.
REQ-017 SHALL drive mem_en=1 and forward we/addr/wdata of the granted requester the same cycle, unless addr[1:0]!=0.
REQ-018 SHALL, for a grant with addr[1:0]!=0, assert gnt, keep mem_en=0, and pulse that requester's err for exactly one cycle on the next cycle.
REQ-019 SHALL, for a granted aligned read, assert that requester's rvalid for exactly one cycle on the next cycle, with rdata=mem_rdata; writes produce no rvalid.
REQ-020 SHALL hold cpu_rdata/dma_rdata at their last returned value between rvalid pulses.
REQ-021 SHALL drive mem_we=0 whenever mem_en=0.

Reset
REQ-022 SHALL, while reset=0, force all gnt, rvalid, err, mem_en and mem_we outputs to 0, rdata to 0, last_owner to DMA, lock state inactive, and lock and stat counters to 0.
REQ-023 SHALL drop any in-flight read response when reset asserts; no rvalid follows reset release.

Configuration
REQ-024 SHALL compile statistics only when DMEM_ARB_STATS_EN is defined.
REQ-025 SHALL, with DMEM_ARB_STATS_EN defined, increment stat_cpu_cnt / stat_dma_cnt per grant and stat_conflict_cnt per cycle with both req high, each saturating at 16'hFFFF.
REQ-026 SHALL, without DMEM_ARB_STATS_EN, tie all stat_* outputs to 0 and instantiate no counter flops.

Structure
REQ-027 SHALL place the owner enum (OWN_CPU, OWN_DMA), the default MAX_LOCK and the stat width constant in package dmem_arb_pkg.
REQ-028 SHALL implement lock tracking and the starvation counter in sub-module dmem_arb_lock_timer; arbitration and muxing remain in dmem_arbiter.

Verification
REQ-029 SHALL cover a CPU-only read at addr 0x100 -> cpu_gnt=1 and mem_en=1 the same cycle, cpu_rvalid=1 next cycle with cpu_rdata=mem_rdata, dma_gnt=0 throughout.
REQ-030 SHALL cover both requesting writes for 4 cycles from reset -> grants alternate CPU,DMA,CPU,DMA, and stat_conflict_cnt=4 when DMEM_ARB_STATS_EN is defined.
REQ-031 SHALL cover DMA holding dma_lock=1 with cpu_req=1 continuously, MAX_LOCK=16 -> dma_gnt for 16 cycles, then cpu_gnt for 1 cycle, then dma_gnt again.
REQ-032 SHALL cover a CPU read at addr 0x102 -> cpu_gnt=1 and mem_en=0 that cycle, cpu_err=1 for one cycle next cycle, cpu_rvalid=0.
REQ-033 SHALL cover reset asserted the cycle after a DMA read grant -> dma_rvalid stays 0 and all outputs read 0 during reset.
REQ-034 SHALL cover a build without DMEM_ARB_STATS_EN running the same traffic as REQ-030 -> all stat_* outputs read 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg -- shared types and constants for the data-memory arbiter.
//   ownerT           : which requester was served most recently (OWN_CPU / OWN_DMA)
//   DEFAULT_MAX_LOCK : default bound on how long a DMA lock may starve a pending CPU
//   STAT_W           : width of the saturating statistics counters
// Optional feature macro used by the arbiter: DMEM_ARB_STATS_EN
package dmem_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } ownerT;

  localparam int DEFAULT_MAX_LOCK = 16;
  localparam int STAT_W           = 16;

endpackage

// File: rtl/dmem_arb_lock_timer.sv
// dmem_arb_lock_timer -- DMA lock tracking and CPU starvation timer.
//   clk, reset  : clock, asynchronous active-low reset
//   cpuReq      : CPU request (raw)
//   dmaReq      : DMA request (raw)
//   dmaLock     : DMA asks to keep ownership after the current grant
//   cpuGnt      : CPU granted this cycle
//   dmaGnt      : DMA granted this cycle
//   lockActive  : DMA held a locked grant last cycle and is still requesting
//   lockExpire  : lock has blocked a waiting CPU for MAX_LOCK cycles; CPU must win now
// Outputs depend only on registered state and request inputs, never on the
// grants, so the arbiter can use them combinationally without a loop.
module dmem_arb_lock_timer
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = DEFAULT_MAX_LOCK
) (
  input  logic clk,
  input  logic reset,
  input  logic cpuReq,
  input  logic dmaReq,
  input  logic dmaLock,
  input  logic cpuGnt,
  input  logic dmaGnt,
  output logic lockActive,
  output logic lockExpire
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  logic             lockHeld_p1;
  logic [CNT_W-1:0] blockCnt;

  assign lockActive = lockHeld_p1 && dmaReq;
  assign lockExpire = lockActive && cpuReq && (blockCnt == CNT_MAX);

  // ---- stage p1: lock ownership and blocked-cycle count ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lockHeld_p1 <= 1'b0;
      blockCnt    <= '0;
    end else begin
      lockHeld_p1 <= dmaGnt && dmaLock;
      if (!cpuReq || !lockActive || cpuGnt) begin
        blockCnt <= '0;
      end else if (blockCnt != CNT_MAX) begin
        blockCnt <= blockCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-master (CPU, DMA) arbiter for a single-port synchronous data memory.
//   clk, reset                         : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata              : CPU request
//   cpu_gnt/rvalid/rdata/err           : CPU grant (same cycle), read data / misalignment error (next cycle)
//   dma_req/we/lock/addr/wdata         : DMA request; dma_lock keeps ownership across cycles
//   dma_gnt/rvalid/rdata/err           : DMA grant and responses, as for the CPU
//   mem_en/we/addr/wdata, mem_rdata    : memory port, read data valid one cycle after mem_en
//   stat_cpu_cnt/dma_cnt/conflict_cnt  : saturating grant and conflict counters
// Optional feature: define DMEM_ARB_STATS_EN to build the statistics counters;
// otherwise the stat_* outputs are tied to zero and no counter flops exist.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DBITS    = 32,
  parameter int MAX_LOCK = DEFAULT_MAX_LOCK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DBITS-1:0]  cpu_addr,
  input  logic [DBITS-1:0]  cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DBITS-1:0]  cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [DBITS-1:0]  dma_addr,
  input  logic [DBITS-1:0]  dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DBITS-1:0]  dma_rdata,
  output logic              dma_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DBITS-1:0]  mem_addr,
  output logic [DBITS-1:0]  mem_wdata,
  input  logic [DBITS-1:0]  mem_rdata,
  output logic [STAT_W-1:0] stat_cpu_cnt,
  output logic [STAT_W-1:0] stat_dma_cnt,
  output logic [STAT_W-1:0] stat_conflict_cnt
);

  ownerT            lastOwner;
  ownerT            lastOwnerNext;
  logic             lockActive;
  logic             lockExpire;
  logic             cpuGntRaw;
  logic             dmaGntRaw;
  logic             selWe;
  logic             selAligned;
  logic [DBITS-1:0] selAddr;
  logic [DBITS-1:0] selWdata;

  logic             cpuRdVld_p1;
  logic             dmaRdVld_p1;
  logic             cpuErr_p1;
  logic             dmaErr_p1;
  logic [DBITS-1:0] cpuRdataHold;
  logic [DBITS-1:0] dmaRdataHold;

  dmem_arb_lock_timer #(
    .MAX_LOCK(MAX_LOCK)
  ) uLockTimer (
    .clk        (clk),
    .reset      (reset),
    .cpuReq     (cpu_req),
    .dmaReq     (dma_req),
    .dmaLock    (dma_lock),
    .cpuGnt     (cpu_gnt),
    .dmaGnt     (dma_gnt),
    .lockActive (lockActive),
    .lockExpire (lockExpire)
  );

  // ---- stage p0: grant decision and memory request ----
  // lockExpire implies both requests are high, so it is resolved in the
  // conflict branch by forcing the CPU to win regardless of lastOwner.
  always_comb begin
    cpuGntRaw = 1'b0;
    dmaGntRaw = 1'b0;
    if (lockActive && !lockExpire) begin
      dmaGntRaw = 1'b1;
    end else if (cpu_req && dma_req) begin
      if (lockExpire || lastOwner == OWN_DMA) cpuGntRaw = 1'b1;
      else                                    dmaGntRaw = 1'b1;
    end else begin
      cpuGntRaw = cpu_req;
      dmaGntRaw = dma_req;
    end
  end

  // Grants are gated by the reset pin itself so they read 0 throughout reset.
  assign cpu_gnt = cpuGntRaw && reset;
  assign dma_gnt = dmaGntRaw && reset;

  always_comb begin
    lastOwnerNext = lastOwner;
    if (cpu_gnt)      lastOwnerNext = OWN_CPU;
    else if (dma_gnt) lastOwnerNext = OWN_DMA;
  end

  assign selWe      = dma_gnt ? dma_we    : cpu_we;
  assign selAddr    = dma_gnt ? dma_addr  : cpu_addr;
  assign selWdata   = dma_gnt ? dma_wdata : cpu_wdata;
  assign selAligned = (selAddr[1:0] == 2'b00);

  assign mem_en    = (cpu_gnt || dma_gnt) && selAligned;
  assign mem_we    = mem_en && selWe;
  assign mem_addr  = selAddr;
  assign mem_wdata = selWdata;

  // ---- stage p1: read response / error return ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastOwner    <= OWN_DMA;
      cpuRdVld_p1  <= 1'b0;
      dmaRdVld_p1  <= 1'b0;
      cpuErr_p1    <= 1'b0;
      dmaErr_p1    <= 1'b0;
      cpuRdataHold <= '0;
      dmaRdataHold <= '0;
    end else begin
      lastOwner    <= lastOwnerNext;
      cpuRdVld_p1  <= cpu_gnt && selAligned && !cpu_we;
      dmaRdVld_p1  <= dma_gnt && selAligned && !dma_we;
      cpuErr_p1    <= cpu_gnt && !selAligned;
      dmaErr_p1    <= dma_gnt && !selAligned;
      if (cpuRdVld_p1) cpuRdataHold <= mem_rdata;
      if (dmaRdVld_p1) dmaRdataHold <= mem_rdata;
    end
  end

  // Memory data is live only in the response cycle; afterwards the hold
  // register keeps presenting the last returned word.
  assign cpu_rvalid = cpuRdVld_p1;
  assign dma_rvalid = dmaRdVld_p1;
  assign cpu_err    = cpuErr_p1;
  assign dma_err    = dmaErr_p1;
  assign cpu_rdata  = cpuRdVld_p1 ? mem_rdata : cpuRdataHold;
  assign dma_rdata  = dmaRdVld_p1 ? mem_rdata : dmaRdataHold;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] cpuCnt;
  logic [STAT_W-1:0] dmaCnt;
  logic [STAT_W-1:0] conflictCnt;

  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + STAT_W'(1) : v;
  endfunction

  // ---- stage p1: statistics ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpuCnt      <= '0;
      dmaCnt      <= '0;
      conflictCnt <= '0;
    end else begin
      cpuCnt      <= satInc(cpuCnt, cpu_gnt);
      dmaCnt      <= satInc(dmaCnt, dma_gnt);
      conflictCnt <= satInc(conflictCnt, cpu_req && dma_req);
    end
  end

  assign stat_cpu_cnt      = cpuCnt;
  assign stat_dma_cnt      = dmaCnt;
  assign stat_conflict_cnt = conflictCnt;
`else
  assign stat_cpu_cnt      = '0;
  assign stat_dma_cnt      = '0;
  assign stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- directed self-checking bench for dmem_arbiter.
// Memory model: a read of address A returns A ^ 32'hA5A5_0000 one cycle later.
module tb_dmem_arbiter;
  localparam int DBITS = 32;
`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [DBITS-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic             cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
  logic [DBITS-1:0] cpu_rdata, dma_rdata;
  logic             mem_en, mem_we;
  logic [DBITS-1:0] mem_addr, mem_wdata;
  logic [DBITS-1:0] mem_rdata = '0;
  logic [15:0]      stat_cpu_cnt, stat_dma_cnt, stat_conflict_cnt;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr ^ 32'hA5A5_0000;
  end

  dmem_arbiter #(.DBITS(DBITS), .MAX_LOCK(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dma_err(dma_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stat_cpu_cnt(stat_cpu_cnt),
    .stat_dma_cnt(stat_dma_cnt), .stat_conflict_cnt(stat_conflict_cnt)
  );

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idle();
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    cpu_req = 1; dma_req = 1; cpu_addr = 32'h100; dma_addr = 32'h200;
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err, mem_en, mem_we} !== 8'h00)
      $display("FAIL reset_ctrl got %b exp 00000000",
               {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err, mem_en, mem_we});
    else passCnt++;
    totalCnt++;
    if ({cpu_rdata, dma_rdata} !== 64'h0) $display("FAIL reset_rdata got %h exp 0", {cpu_rdata, dma_rdata});
    else passCnt++;
    totalCnt++;
    if ({stat_cpu_cnt, stat_dma_cnt, stat_conflict_cnt} !== 48'h0)
      $display("FAIL reset_stats got %h exp 0", {stat_cpu_cnt, stat_dma_cnt, stat_conflict_cnt});
    else passCnt++;
    idle();
    nextCycle();
    reset = 1;
  endtask

  task automatic test_cpu_read();
    idle();
    cpu_req = 1; cpu_addr = 32'h100;
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt, mem_en, mem_we} !== 4'b1010)
      $display("FAIL cpu_read_gnt got %b exp 1010", {cpu_gnt, dma_gnt, mem_en, mem_we});
    else passCnt++;
    totalCnt++;
    if (mem_addr !== 32'h100) $display("FAIL cpu_read_addr got %h exp 00000100", mem_addr);
    else passCnt++;
    nextCycle();
    idle();
    @(negedge clk);
    totalCnt++;
    if ({cpu_rvalid, dma_gnt, dma_rvalid} !== 3'b100)
      $display("FAIL cpu_read_rvalid got %b exp 100", {cpu_rvalid, dma_gnt, dma_rvalid});
    else passCnt++;
    totalCnt++;
    if (cpu_rdata !== 32'hA5A5_0100) $display("FAIL cpu_read_rdata got %h exp a5a50100", cpu_rdata);
    else passCnt++;
    nextCycle();
    @(negedge clk);
    totalCnt++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hA5A5_0100)
      $display("FAIL cpu_read_hold got %b/%h exp 0/a5a50100", cpu_rvalid, cpu_rdata);
    else passCnt++;
    nextCycle();
  endtask

  task automatic test_back_to_back();
    idle();
    cpu_req = 1; cpu_addr = 32'h10;
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt, mem_en} !== 3'b101) $display("FAIL b2b_cpu_gnt got %b exp 101", {cpu_gnt, dma_gnt, mem_en});
    else passCnt++;
    nextCycle();
    idle();
    dma_req = 1; dma_addr = 32'h20;
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt, mem_en, cpu_rvalid} !== 4'b0111)
      $display("FAIL b2b_dma_gnt got %b exp 0111", {cpu_gnt, dma_gnt, mem_en, cpu_rvalid});
    else passCnt++;
    totalCnt++;
    if (cpu_rdata !== 32'hA5A5_0010) $display("FAIL b2b_cpu_rdata got %h exp a5a50010", cpu_rdata);
    else passCnt++;
    nextCycle();
    idle();
    @(negedge clk);
    totalCnt++;
    if ({cpu_rvalid, dma_rvalid} !== 2'b01) $display("FAIL b2b_dma_rvalid got %b exp 01", {cpu_rvalid, dma_rvalid});
    else passCnt++;
    totalCnt++;
    if (dma_rdata !== 32'hA5A5_0020 || cpu_rdata !== 32'hA5A5_0010)
      $display("FAIL b2b_rdata got %h/%h exp a5a50020/a5a50010", dma_rdata, cpu_rdata);
    else passCnt++;
    nextCycle();
  endtask

  task automatic test_misaligned();
    idle();
    cpu_req = 1; cpu_addr = 32'h102;
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt, mem_en, mem_we} !== 4'b1000)
      $display("FAIL misalign_gnt got %b exp 1000", {cpu_gnt, dma_gnt, mem_en, mem_we});
    else passCnt++;
    nextCycle();
    idle();
    @(negedge clk);
    totalCnt++;
    if ({cpu_err, cpu_rvalid, dma_err} !== 3'b100)
      $display("FAIL misalign_err got %b exp 100", {cpu_err, cpu_rvalid, dma_err});
    else passCnt++;
    nextCycle();
    @(negedge clk);
    totalCnt++;
    if ({cpu_err, cpu_rvalid} !== 2'b00) $display("FAIL misalign_err_pulse got %b exp 00", {cpu_err, cpu_rvalid});
    else passCnt++;
    nextCycle();
  endtask

  task automatic test_conflict();
    logic [3:0]  expGnt [4] = '{4'b1011, 4'b0111, 4'b1011, 4'b0111};
    logic [31:0] expWd;
    logic [15:0] expHalf;
    logic [15:0] expConf;
    doReset();
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = DBITS'(i);
      dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = DBITS'(100 + i);
      expWd = (i % 2 == 0) ? 32'(i) : 32'(100 + i);
      @(negedge clk);
      totalCnt++;
      if ({cpu_gnt, dma_gnt, mem_en, mem_we} !== expGnt[i])
        $display("FAIL conflict_gnt[%0d] got %b exp %b", i, {cpu_gnt, dma_gnt, mem_en, mem_we}, expGnt[i]);
      else passCnt++;
      totalCnt++;
      if (mem_wdata !== expWd) $display("FAIL conflict_wdata[%0d] got %0d exp %0d", i, mem_wdata, expWd);
      else passCnt++;
      nextCycle();
    end
    idle();
    expHalf = STATS ? 16'd2 : 16'd0;
    expConf = STATS ? 16'd4 : 16'd0;
    @(negedge clk);
    totalCnt++;
    if ({cpu_rvalid, dma_rvalid} !== 2'b00) $display("FAIL conflict_no_rvalid got %b exp 00", {cpu_rvalid, dma_rvalid});
    else passCnt++;
    totalCnt++;
    if ({stat_cpu_cnt, stat_dma_cnt, stat_conflict_cnt} !== {expHalf, expHalf, expConf})
      $display("FAIL conflict_stats got %0d/%0d/%0d exp %0d/%0d/%0d", stat_cpu_cnt, stat_dma_cnt,
               stat_conflict_cnt, expHalf, expHalf, expConf);
    else passCnt++;
    nextCycle();
  endtask

  task automatic test_lock();
    doReset();
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h200;
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt} !== 2'b01) $display("FAIL lock_start got %b exp 01", {cpu_gnt, dma_gnt});
    else passCnt++;
    nextCycle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      totalCnt++;
      if ({cpu_gnt, dma_gnt} !== 2'b01) $display("FAIL lock_hold[%0d] got %b exp 01", i, {cpu_gnt, dma_gnt});
      else passCnt++;
      nextCycle();
    end
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) $display("FAIL lock_expire got %b exp 10", {cpu_gnt, dma_gnt});
    else passCnt++;
    nextCycle();
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt} !== 2'b01) $display("FAIL lock_regrant got %b exp 01", {cpu_gnt, dma_gnt});
    else passCnt++;
    nextCycle();
    idle();
  endtask

  task automatic test_reset_inflight();
    idle();
    dma_req = 1; dma_addr = 32'h400;
    @(negedge clk);
    totalCnt++;
    if ({dma_gnt, mem_en} !== 2'b11) $display("FAIL inflight_gnt got %b exp 11", {dma_gnt, mem_en});
    else passCnt++;
    nextCycle();
    reset = 0;
    @(negedge clk);
    totalCnt++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err, mem_en, mem_we} !== 8'h00)
      $display("FAIL inflight_reset_ctrl got %b exp 00000000",
               {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err, mem_en, mem_we});
    else passCnt++;
    totalCnt++;
    if ({cpu_rdata, dma_rdata} !== 64'h0) $display("FAIL inflight_reset_rdata got %h exp 0", {cpu_rdata, dma_rdata});
    else passCnt++;
    nextCycle();
    idle();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      totalCnt++;
      if (dma_rvalid !== 1'b0) $display("FAIL inflight_no_rvalid[%0d] got %b exp 0", i, dma_rvalid);
      else passCnt++;
      nextCycle();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_cpu_read();
    test_back_to_back();
    test_misaligned();
    test_conflict();
    test_lock();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
